// File: rtl/gbalu_core.sv
// gbalu_core: register file plus Z/N/H/C ALU with valid/ready handshake and multi-cycle rotate.
module gbalu_core #(
    parameter int WIDTH = 8,
    parameter int NREGS = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       instruction,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             ready,
    output logic [WIDTH-1:0] probe,
    output logic [3:0]       flags,
    output logic             done
);
    localparam int KW = $clog2(WIDTH);
    typedef enum logic {IDLE, ROT} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [3:0] flags_q, flags_d;
    logic [KW-1:0] cnt_q, cnt_d;
    logic done_q, done_d;
    logic [1:0] cls;
    logic [2:0] op, r;
    logic [KW-1:0] k;
    logic [WIDTH-1:0] a, rd, b, rol, alu_res;
    logic [WIDTH:0] sum, diff;
    logic [4:0] hsum, hdiff;
    logic cin, alu_n, alu_h, alu_c;
    assign cls = instruction[7:6];
    assign op = instruction[5:3];
    assign r = instruction[2:0];
    assign k = data[KW-1:0];
    assign a = regs_q[0];
    assign rol = {a[WIDTH-2:0], a[WIDTH-1]};
    assign b = (cls == 2'b01) ? rd : data;
    assign cin = op[0] & ~op[2] & flags_q[0];
    assign sum = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
    assign diff = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(cin);
    assign hsum = {1'b0, a[3:0]} + {1'b0, b[3:0]} + 5'(cin);
    assign hdiff = {1'b0, a[3:0]} - {1'b0, b[3:0]} - 5'(cin);
    assign ready = (state_q == IDLE);
    assign probe = a;
    assign flags = flags_q;
    assign done = done_q;
    always_comb begin
        rd = '0;
        for (int i = 0; i < NREGS; i++) if (r == 3'(i)) rd = regs_q[i];
    end
    always_comb begin
        alu_res = sum[WIDTH-1:0];
        alu_n = 1'b0;
        alu_h = hsum[4];
        alu_c = sum[WIDTH];
        case (op)
            3'd2, 3'd3, 3'd7: begin
                alu_res = diff[WIDTH-1:0];
                alu_n = 1'b1;
                alu_h = hdiff[4];
                alu_c = diff[WIDTH];
            end
            3'd4: begin alu_res = a & b; alu_h = 1'b1; alu_c = 1'b0; end
            3'd5: begin alu_res = a ^ b; alu_h = 1'b0; alu_c = 1'b0; end
            3'd6: begin alu_res = a | b; alu_h = 1'b0; alu_c = 1'b0; end
            default: ;
        endcase
    end
    always_comb begin
        regs_d = regs_q;
        flags_d = flags_q;
        state_d = state_q;
        cnt_d = cnt_q;
        done_d = 1'b0;
        if (state_q == ROT) begin
            regs_d[0] = rol;
            cnt_d = cnt_q - KW'(1);
            if (cnt_q == KW'(1)) begin
                flags_d = {rol == '0, 2'b00, a[WIDTH-1]};
                state_d = IDLE;
                done_d = 1'b1;
            end
        end else if (valid) begin
            done_d = 1'b1;
            case (cls)
                2'b00: for (int i = 0; i < NREGS; i++) if (r == 3'(i)) regs_d[i] = data;
                2'b01, 2'b10: begin
                    flags_d = {alu_res == '0, alu_n, alu_h, alu_c};
                    if (op != 3'd7) regs_d[0] = alu_res;
                end
                default: if (op == 3'd0) begin
                    if (k == '0) flags_d = {a == '0, 3'b000};
                    else begin
                        state_d = ROT;
                        cnt_d = k;
                        done_d = 1'b0;
                    end
                end
            endcase
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            regs_q <= '{default: '0};
            flags_q <= '0;
            state_q <= IDLE;
            cnt_q <= '0;
            done_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            flags_q <= flags_d;
            state_q <= state_d;
            cnt_q <= cnt_d;
            done_q <= done_d;
        end
    end
endmodule

// File: tb/tb_gbalu_core.sv
// tb_gbalu_core: directed vectors for gbalu_core at WIDTH=8/NREGS=8, NREGS=4 and WIDTH=16.
module tb_gbalu_core;
    typedef struct {
        logic [7:0] ins;
        logic [7:0] dat;
        logic [7:0] exp_a;
        logic [3:0] exp_f;
    } vec_t;
    logic clk = 1'b0, rst = 1'b1;
    logic [7:0] ins = '0, d8 = '0;
    logic [15:0] d16 = '0;
    logic v8 = 1'b0, v4 = 1'b0, v16 = 1'b0;
    logic rdy8, rdy4, rdy16, dn8, dn4, dn16;
    logic [7:0] p8, p4;
    logic [15:0] p16;
    logic [3:0] f8, f4, f16;
    int total = 0, bad = 0;
    always #5 clk = ~clk;
    gbalu_core #(.WIDTH(8), .NREGS(8)) u8 (.clock(clk), .reset(rst), .instruction(ins), .data(d8),
        .valid(v8), .ready(rdy8), .probe(p8), .flags(f8), .done(dn8));
    gbalu_core #(.WIDTH(8), .NREGS(4)) u4 (.clock(clk), .reset(rst), .instruction(ins), .data(d8),
        .valid(v4), .ready(rdy4), .probe(p4), .flags(f4), .done(dn4));
    gbalu_core #(.WIDTH(16), .NREGS(8)) u16 (.clock(clk), .reset(rst), .instruction(ins), .data(d16),
        .valid(v16), .ready(rdy16), .probe(p16), .flags(f16), .done(dn16));
    vec_t tv [18] = '{
        '{8'h00, 8'h3A, 8'h3A, 4'h0}, '{8'h01, 8'hC6, 8'h3A, 4'h0},
        '{8'h41, 8'h00, 8'h00, 4'hB}, '{8'h00, 8'hE1, 8'hE1, 4'hB},
        '{8'h04, 8'h0F, 8'hE1, 4'hB}, '{8'h4C, 8'h00, 8'hF1, 4'h2},
        '{8'h00, 8'h3E, 8'h3E, 4'h2}, '{8'h90, 8'h0F, 8'h2F, 4'h6},
        '{8'hB8, 8'h2F, 8'h2F, 4'hC}, '{8'hA0, 8'h0F, 8'h0F, 4'h2},
        '{8'hA8, 8'h0F, 8'h00, 4'h8}, '{8'hB0, 8'h81, 8'h81, 4'h0},
        '{8'h90, 8'h82, 8'hFF, 4'h7}, '{8'h98, 8'h0F, 8'hEF, 4'h6},
        '{8'h88, 8'h11, 8'h00, 4'hB}, '{8'hC0, 8'h08, 8'h00, 4'h8},
        '{8'h80, 8'h01, 8'h01, 4'h0}, '{8'hC8, 8'h55, 8'h01, 4'h0}
    };
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask
    initial begin
        int n;
        cyc();
        cyc();
        chk("rst_probe8", 32'(p8), 0); chk("rst_flags8", 32'(f8), 0);
        chk("rst_ready8", 32'(rdy8), 1); chk("rst_done8", 32'(dn8), 0);
        chk("rst_probe16", 32'(p16), 0); chk("rst_ready4", 32'(rdy4), 1);
        rst = 1'b0;
        for (int i = 0; i < 18; i++) begin
            ins = tv[i].ins; d8 = tv[i].dat; v8 = 1'b1;
            cyc();
            chk($sformatf("v%0d_probe", i), 32'(p8), 32'(tv[i].exp_a));
            chk($sformatf("v%0d_flags", i), 32'(f8), 32'(tv[i].exp_f));
            chk($sformatf("v%0d_done", i), 32'(dn8), 1);
            chk($sformatf("v%0d_ready", i), 32'(rdy8), 1);
        end
        v8 = 1'b0;
        cyc();
        chk("idle_done", 32'(dn8), 0);
        ins = 8'h00; d8 = 8'h85; v8 = 1'b1; cyc();
        ins = 8'hB8; d8 = 8'h00; cyc();
        chk("cp0_flags", 32'(f8), 4);
        ins = 8'hC0; d8 = 8'h03; cyc();
        chk("rot0_ready", 32'(rdy8), 0); chk("rot0_done", 32'(dn8), 0); chk("rot0_probe", 32'(p8), 8'h85);
        ins = 8'h00; d8 = 8'hFF; cyc();
        chk("rot1_probe", 32'(p8), 8'h0B); chk("rot1_ready", 32'(rdy8), 0);
        chk("rot1_flags", 32'(f8), 4); chk("rot1_done", 32'(dn8), 0);
        cyc();
        chk("rot2_probe", 32'(p8), 8'h16); chk("rot2_ready", 32'(rdy8), 0);
        cyc();
        chk("rot3_probe", 32'(p8), 8'h2C); chk("rot3_ready", 32'(rdy8), 1);
        chk("rot3_done", 32'(dn8), 1); chk("rot3_flags", 32'(f8), 0);
        v8 = 1'b0; cyc();
        chk("rot4_done", 32'(dn8), 0); chk("rot4_probe", 32'(p8), 8'h2C);
        ins = 8'h00; d8 = 8'h85; v8 = 1'b1; cyc();
        ins = 8'hB8; d8 = 8'h00; cyc();
        ins = 8'hC0; d8 = 8'h05; cyc();
        chk("abort_busy1", 32'(rdy8), 0);
        v8 = 1'b0; cyc();
        chk("abort_busy2", 32'(rdy8), 0);
        rst = 1'b1; cyc();
        chk("abort_probe", 32'(p8), 0); chk("abort_flags", 32'(f8), 0);
        chk("abort_ready", 32'(rdy8), 1); chk("abort_done", 32'(dn8), 0);
        rst = 1'b0; cyc();
        chk("abort_done2", 32'(dn8), 0); chk("abort_probe2", 32'(p8), 0);
        ins = 8'h06; d8 = 8'h55; v4 = 1'b1; cyc();
        chk("oor_ld_done", 32'(dn4), 1);
        ins = 8'h46; cyc();
        chk("oor_add_probe", 32'(p4), 0); chk("oor_add_flags", 32'(f4), 8);
        ins = 8'h00; d8 = 8'h12; cyc();
        ins = 8'h42; cyc();
        chk("alias_probe", 32'(p4), 8'h12); chk("alias_flags", 32'(f4), 0);
        v4 = 1'b0;
        ins = 8'h00; d16 = 16'hFFFF; v16 = 1'b1; cyc();
        chk("w16_ld", 32'(p16), 16'hFFFF);
        ins = 8'h80; d16 = 16'h0001; cyc();
        chk("w16_add_probe", 32'(p16), 0); chk("w16_add_flags", 32'(f16), 4'hB);
        chk("w16_add_done", 32'(dn16), 1);
        ins = 8'hC0; d16 = 16'h000F; cyc();
        v16 = 1'b0;
        n = 0;
        while (!rdy16 && n < 40) begin
            n++;
            cyc();
        end
        chk("w16_busy", 32'(n), 15); chk("w16_rot_done", 32'(dn16), 1);
        chk("w16_rot_flags", 32'(f16), 8); chk("w16_rot_probe", 32'(p16), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
